nmr_bstrm_scan_ctrl: RTL and testbench
======================================

# nmr_bstrm_scan_ctrl

Scan sequencer for the NMR bitstream FIFO player. On an SoC command it runs the pulse-bitstream player for a programmed number of scans: it waits for the FIFO to prefill, pulses the player's start input, waits for end-of-bitstream, then times the repetition delay (TR) before the next scan. It sits between the SoC control registers and the bitstream player (START/STOP/D_END) and also reports status and handles aborts.

## Interface

Parameters:
- LEVEL_W, 10, width of FIFO fill-level input
- PREFILL_LVL, 16, minimum FIFO words before a scan is armed
- PREFILL_TMO, 65535, max cycles spent waiting for prefill before error
- ABORT_HOLD, 4, cycles BS_STOP stays asserted after an abort

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CMD_START  in  1  SoC start request, sampled only in IDLE
- CMD_ABORT  in  1  SoC abort request, level or pulse
- NUM_SCANS  in  16  scans to run, latched on accepted CMD_START
- TR_DELAY  in  32  inter-scan delay in cycles, latched on accepted CMD_START
- FIFO_LEVEL  in  LEVEL_W  current bitstream FIFO fill level
- BS_START  out  1  one-cycle start pulse to bitstream player
- BS_STOP  out  1  stop to bitstream player (abort only)
- BS_DEND  in  1  end-of-bitstream from player
- BUSY  out  1  high whenever state is not IDLE
- DONE  out  1  one-cycle pulse when all scans complete normally
- SCAN_CNT  out  16  completed scans in current run
- ABORTED  out  1  sticky, set by abort, cleared on next accepted CMD_START
- ERR_TMO  out  1  sticky, set by prefill timeout, cleared on next accepted CMD_START

## Operation

- States: IDLE, PREFILL, ARM, RUN, DELAY, FIN, ABORT.
- IDLE: CMD_START=1 → latch NUM_SCANS/TR_DELAY, clear SCAN_CNT/ABORTED/ERR_TMO; if NUM_SCANS=0 → FIN, else → PREFILL.
- PREFILL: FIFO_LEVEL ≥ PREFILL_LVL → ARM. Wait counter reset on entry; reaching PREFILL_TMO cycles without threshold → set ERR_TMO, → IDLE (no DONE, no BS_START).
- ARM: exactly one cycle, BS_START=1 (registered, asserted during ARM), → RUN.
- RUN: waits for BS_DEND=1; then SCAN_CNT+1; if new count = latched NUM_SCANS → FIN; else TR_DELAY=0 → PREFILL, otherwise → DELAY with counter loaded.
- DELAY: lasts exactly latched TR_DELAY cycles, then → PREFILL.
- FIN: one cycle, DONE=1, → IDLE.
- ABORT: CMD_ABORT=1 in any non-IDLE state → ABORT next cycle; BS_STOP=1 for ABORT_HOLD cycles, ABORTED set, then → IDLE. CMD_ABORT in IDLE ignored.
- BS_DEND outside RUN ignored. CMD_START outside IDLE ignored.
- Counters: TR counter 32-bit, prefill counter wide enough for PREFILL_TMO, SCAN_CNT 16-bit; no wrap possible since NUM_SCANS ≤ 65535.

## Timing

- Reset (RST_N=0, asynchronous): state IDLE; BS_START=0, BS_STOP=0, BUSY=0, DONE=0, SCAN_CNT=0, ABORTED=0, ERR_TMO=0; all counters 0.
- CMD_START at cycle N (IDLE) → BUSY=1 from N+1; with FIFO already ≥ PREFILL_LVL, PREFILL at N+1, BS_START at N+2.
- BS_DEND at cycle M in RUN → SCAN_CNT updated at M+1.
- Scan-to-scan BS_START spacing = (BS_DEND offset after BS_START) + TR_DELAY + 2 with full FIFO (TR_DELAY=0: offset + 2).
- Last scan: BS_DEND at M → DONE pulse at M+1, BUSY=0 at M+2.
- Simultaneous CMD_ABORT and BS_DEND in RUN: abort wins, SCAN_CNT not incremented, no DONE.
- Simultaneous CMD_ABORT and PREFILL timeout: abort wins, ERR_TMO not set.
- Reset mid-run: all outputs return to reset values immediately; no BS_STOP emitted.

## Test plan

- NUM_SCANS=3, TR_DELAY=10, FIFO_LEVEL=64, BS_DEND 20 cycles after each BS_START → three BS_START pulses 32 cycles apart, SCAN_CNT 1,2,3, single DONE, BUSY drops 2 cycles after third BS_DEND.
- NUM_SCANS=0 → no BS_START, DONE one cycle after start, SCAN_CNT=0.
- FIFO_LEVEL=8 for 100 cycles then 20 (PREFILL_LVL=16) → BS_START exactly 2 cycles after level crosses; PREFILL_TMO=50 with level held at 8 → ERR_TMO=1 after 50 PREFILL cycles, BUSY=0, no DONE.
- CMD_ABORT during second scan's RUN → BS_STOP high 4 cycles, ABORTED=1, SCAN_CNT=1, no DONE; next CMD_START clears ABORTED.
- CMD_ABORT same cycle as BS_DEND of final scan → ABORTED=1, SCAN_CNT unchanged, no DONE.
- RST_N low mid-DELAY → all outputs zero asynchronously; stray BS_DEND/CMD_START during run ignored.

Source files
------------

// File: rtl/nmr_bstrm_scan_ctrl.sv
// nmr_bstrm_scan_ctrl: scan sequencer for the NMR bitstream FIFO player (prefill, start, wait end, TR delay).
// Latency: CMD_START -> BS_START 2 cycles with a full FIFO; BS_DEND -> SCAN_CNT / DONE 1 cycle; BUSY is registered.
// Backpressure: a scan is armed only once FIFO_LEVEL >= PREFILL_LVL; after PREFILL_TMO cycles of waiting the run ends with ERR_TMO.
//
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   CMD_START, CMD_ABORT   SoC commands (start sampled in IDLE only, abort ignored in IDLE)
//   NUM_SCANS, TR_DELAY    run configuration, latched when a start is accepted
//   FIFO_LEVEL             bitstream FIFO fill level
//   BS_START, BS_STOP      start pulse / abort stop towards the bitstream player
//   BS_DEND                end-of-bitstream from the player (honoured in RUN only)
//   BUSY, DONE, SCAN_CNT   run status: not-idle, normal completion pulse, completed scans
//   ABORTED, ERR_TMO       sticky error flags, cleared by the next accepted start
module nmr_bstrm_scan_ctrl #(
   parameter int LEVEL_W     = 10,
   parameter int PREFILL_LVL = 16,
   parameter int PREFILL_TMO = 65535,
   parameter int ABORT_HOLD  = 4
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               CMD_START,
   input  logic               CMD_ABORT,
   input  logic [15:0]        NUM_SCANS,
   input  logic [31:0]        TR_DELAY,
   input  logic [LEVEL_W-1:0] FIFO_LEVEL,
   output logic               BS_START,
   output logic               BS_STOP,
   input  logic               BS_DEND,
   output logic               BUSY,
   output logic               DONE,
   output logic [15:0]        SCAN_CNT,
   output logic               ABORTED,
   output logic               ERR_TMO
);

   // Prefill counter holds 0 .. PREFILL_TMO-1, abort counter 0 .. ABORT_HOLD-1.
   localparam int PW = (PREFILL_TMO > 1) ? $clog2(PREFILL_TMO) : 1;
   localparam int HW = (ABORT_HOLD > 1) ? $clog2(ABORT_HOLD) : 1;
   localparam logic [PW-1:0]      PTMO_LAST = PW'(PREFILL_TMO - 1);
   localparam logic [HW-1:0]      HOLD_LAST = HW'(ABORT_HOLD - 1);
   localparam logic [LEVEL_W-1:0] LVL_MIN   = LEVEL_W'(PREFILL_LVL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFILL,
      S_ARM,
      S_RUN,
      S_DELAY,
      S_FIN,
      S_ABORT
   } state_t;

   state_t        state_q;
   logic [15:0]   nscans_q;
   logic [31:0]   tr_q;
   logic [31:0]   dly_cnt_q;
   logic [PW-1:0] pf_cnt_q;
   logic [HW-1:0] hold_cnt_q;
   logic [15:0]   scan_cnt_q;
   logic          lvl_ok_q;
   logic          bs_start_q;
   logic          bs_stop_q;
   logic          busy_q;
   logic          done_q;
   logic          aborted_q;
   logic          err_tmo_q;

   logic [15:0]   scan_cnt_d;
   logic          abort_d;

   assign scan_cnt_d = scan_cnt_q + 16'd1;
   // An abort arriving while already aborting does not restart the hold,
   // so a level-held CMD_ABORT still lets the block return to IDLE.
   assign abort_d    = CMD_ABORT && (state_q != S_IDLE) && (state_q != S_ABORT);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         nscans_q   <= '0;
         tr_q       <= '0;
         dly_cnt_q  <= '0;
         pf_cnt_q   <= '0;
         hold_cnt_q <= '0;
         scan_cnt_q <= '0;
         lvl_ok_q   <= 1'b0;
         bs_start_q <= 1'b0;
         bs_stop_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         // Threshold compare is registered to keep FIFO_LEVEL off the FSM
         // path; a level crossing therefore reaches ARM two cycles later.
         lvl_ok_q   <= (FIFO_LEVEL >= LVL_MIN);
         bs_start_q <= 1'b0;
         done_q     <= 1'b0;

         if (abort_d) begin
            // Abort outranks end-of-bitstream and prefill timeout in the same cycle.
            state_q    <= S_ABORT;
            bs_stop_q  <= 1'b1;
            aborted_q  <= 1'b1;
            hold_cnt_q <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (CMD_START) begin
                     nscans_q   <= NUM_SCANS;
                     tr_q       <= TR_DELAY;
                     scan_cnt_q <= '0;
                     aborted_q  <= 1'b0;
                     err_tmo_q  <= 1'b0;
                     busy_q     <= 1'b1;
                     if (NUM_SCANS == 16'd0) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                     end else begin
                        state_q  <= S_PREFILL;
                        pf_cnt_q <= '0;
                     end
                  end
               end
               S_PREFILL: begin
                  if (lvl_ok_q) begin
                     state_q    <= S_ARM;
                     bs_start_q <= 1'b1;
                  end else if (pf_cnt_q == PTMO_LAST) begin
                     state_q   <= S_IDLE;
                     err_tmo_q <= 1'b1;
                     busy_q    <= 1'b0;
                  end else begin
                     pf_cnt_q <= pf_cnt_q + 1'b1;
                  end
               end
               S_ARM: begin
                  state_q <= S_RUN;
               end
               S_RUN: begin
                  if (BS_DEND) begin
                     scan_cnt_q <= scan_cnt_d;
                     if (scan_cnt_d == nscans_q) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                     end else if (tr_q == 32'd0) begin
                        state_q  <= S_PREFILL;
                        pf_cnt_q <= '0;
                     end else begin
                        // Count TR-1 down to 0 inclusive: exactly TR cycles in DELAY.
                        state_q   <= S_DELAY;
                        dly_cnt_q <= tr_q - 32'd1;
                     end
                  end
               end
               S_DELAY: begin
                  if (dly_cnt_q == 32'd0) begin
                     state_q  <= S_PREFILL;
                     pf_cnt_q <= '0;
                  end else begin
                     dly_cnt_q <= dly_cnt_q - 32'd1;
                  end
               end
               S_FIN: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               S_ABORT: begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     state_q   <= S_IDLE;
                     bs_stop_q <= 1'b0;
                     busy_q    <= 1'b0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q   <= S_IDLE;
                  bs_stop_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign BS_START = bs_start_q;
   assign BS_STOP  = bs_stop_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign SCAN_CNT = scan_cnt_q;
   assign ABORTED  = aborted_q;
   assign ERR_TMO  = err_tmo_q;

endmodule

// File: tb/tb_nmr_bstrm_scan_ctrl.sv
// tb_nmr_bstrm_scan_ctrl: bench for the scan sequencer; a player model answers BS_START with BS_DEND.
// Expected pulse times come from the run-level timing rules (start, spacing, completion).
// Second instance uses a short prefill timeout for the timeout / abort-vs-timeout cases.
module tb_nmr_bstrm_scan_ctrl;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_abort = 1'b0;
   logic [15:0] num_scans = '0;
   logic [31:0] tr_delay  = '0;
   logic [9:0]  fifo_lvl  = '0;
   logic        dend_man  = 1'b0;
   logic        dend_ply  = 1'b0;
   logic        bs_dend;
   logic        bs_start, bs_stop, busy, done, aborted, err_tmo;
   logic [15:0] scan_cnt;

   logic        t_start = 1'b0;
   logic        t_abort = 1'b0;
   logic [9:0]  t_lvl   = '0;
   logic        t_bs_start, t_bs_stop, t_busy, t_done, t_aborted, t_err_tmo;
   logic [15:0] t_scan_cnt;

   int errors   = 0;
   int checks   = 0;
   int cyc      = 0;
   int dend_ofs = 1;
   int dend_at  = -1;
   int start_log[$];
   int done_log[$];
   int stop_log[$];
   int rise_log[$];
   int fall_log[$];
   int sc_cyc[$];
   int sc_val[$];
   logic        busy_prev = 1'b0;
   logic [15:0] sc_prev   = '0;

   assign bs_dend = dend_man | dend_ply;

   nmr_bstrm_scan_ctrl dut (
      .CLK(clk), .RST_N(rst_n), .CMD_START(cmd_start), .CMD_ABORT(cmd_abort),
      .NUM_SCANS(num_scans), .TR_DELAY(tr_delay), .FIFO_LEVEL(fifo_lvl),
      .BS_START(bs_start), .BS_STOP(bs_stop), .BS_DEND(bs_dend), .BUSY(busy),
      .DONE(done), .SCAN_CNT(scan_cnt), .ABORTED(aborted), .ERR_TMO(err_tmo)
   );

   nmr_bstrm_scan_ctrl #(.PREFILL_TMO(50)) dut_t (
      .CLK(clk), .RST_N(rst_n), .CMD_START(t_start), .CMD_ABORT(t_abort),
      .NUM_SCANS(16'd1), .TR_DELAY(32'd0), .FIFO_LEVEL(t_lvl),
      .BS_START(t_bs_start), .BS_STOP(t_bs_stop), .BS_DEND(1'b0), .BUSY(t_busy),
      .DONE(t_done), .SCAN_CNT(t_scan_cnt), .ABORTED(t_aborted), .ERR_TMO(t_err_tmo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Player model: end-of-bitstream dend_ofs cycles after each observed BS_START.
   always @(posedge clk) begin
      #1;
      dend_ply = (dend_at >= 0) && (cyc == dend_at);
   end

   // Event logger, sampled mid-cycle.
   always @(negedge clk) begin
      if (bs_start) begin
         start_log.push_back(cyc);
         dend_at = cyc + dend_ofs;
      end
      if (done)    done_log.push_back(cyc);
      if (bs_stop) stop_log.push_back(cyc);
      if (busy && !busy_prev) rise_log.push_back(cyc);
      if (!busy && busy_prev) fall_log.push_back(cyc);
      busy_prev = busy;
      if (scan_cnt != sc_prev && scan_cnt != 16'd0) begin
         sc_cyc.push_back(cyc);
         sc_val.push_back(int'(scan_cnt));
      end
      sc_prev = scan_cnt;
   end

   task automatic advance_to(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic start_run(input int n, input int tr, output int n0);
      @(posedge clk); #1;
      num_scans = 16'(n);
      tr_delay  = 32'(tr);
      cmd_start = 1'b1;
      n0        = cyc;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      // Scramble the configuration inputs: the run must use the latched copies.
      num_scans = 16'($urandom_range(0, 65535));
      tr_delay  = $urandom;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int i = 0;
      while (busy !== 1'b0 && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_wait: busy=%b after %0d cycles, expected 0", nm, busy, budget);
      end
   endtask

   task automatic wait_starts(input int cnt, input int budget, input string nm);
      int i = 0;
      while (start_log.size() < cnt && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      checks++;
      if (start_log.size() < cnt) begin
         errors++;
         $display("FAIL %s start_wait: %0d starts logged, expected %0d", nm, start_log.size(), cnt);
      end
   endtask

   // Full run with a full FIFO; every timing point is predicted from n, tr, d.
   task automatic run_scans(input int n, input int tr, input int d, input string nm);
      int n0, per, s_exp, exp_done;
      int sb, db, rb, fb, cb;
      sb = start_log.size(); db = done_log.size(); rb = rise_log.size();
      fb = fall_log.size();  cb = sc_cyc.size();
      dend_ofs = d;
      fifo_lvl = 10'($urandom_range(16, 1023));
      start_run(n, tr, n0);
      wait_idle(n * (d + tr + 4) + 20, nm);
      repeat (2) @(posedge clk);
      #1;
      per      = d + tr + 2;
      exp_done = (n == 0) ? n0 + 1 : n0 + 2 + (n - 1) * per + d + 1;

      checks++;
      if (start_log.size() - sb != n) begin
         errors++;
         $display("FAIL %s start_count: got %0d, expected %0d", nm, start_log.size() - sb, n);
      end
      for (int k = 0; k < n && sb + k < start_log.size(); k++) begin
         s_exp = n0 + 2 + k * per;
         checks++;
         if (start_log[sb + k] != s_exp) begin
            errors++;
            $display("FAIL %s start[%0d]: got cycle %0d, expected %0d", nm, k, start_log[sb + k], s_exp);
         end
      end
      checks++;
      if (done_log.size() - db != 1) begin
         errors++;
         $display("FAIL %s done_count: got %0d, expected 1", nm, done_log.size() - db);
      end else begin
         checks++;
         if (done_log[db] != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", nm, done_log[db], exp_done);
         end
      end
      checks++;
      if (rise_log.size() <= rb || rise_log[rb] != n0 + 1) begin
         errors++;
         $display("FAIL %s busy_rise: got %0d, expected %0d", nm,
                  (rise_log.size() > rb) ? rise_log[rb] : -1, n0 + 1);
      end
      checks++;
      if (fall_log.size() <= fb || fall_log[fb] != exp_done + 1) begin
         errors++;
         $display("FAIL %s busy_fall: got %0d, expected %0d", nm,
                  (fall_log.size() > fb) ? fall_log[fb] : -1, exp_done + 1);
      end
      checks++;
      if (int'(scan_cnt) != n) begin
         errors++;
         $display("FAIL %s scan_cnt_final: got %0d, expected %0d", nm, scan_cnt, n);
      end
      checks++;
      if (sc_cyc.size() - cb != n) begin
         errors++;
         $display("FAIL %s scan_cnt_steps: got %0d, expected %0d", nm, sc_cyc.size() - cb, n);
      end
      for (int k = 0; k < n && cb + k < sc_cyc.size(); k++) begin
         checks++;
         if (sc_cyc[cb + k] != n0 + 2 + k * per + d + 1 || sc_val[cb + k] != k + 1) begin
            errors++;
            $display("FAIL %s scan_cnt_step[%0d]: got %0d at %0d, expected %0d at %0d", nm, k,
                     sc_val[cb + k], sc_cyc[cb + k], k + 1, n0 + 2 + k * per + d + 1);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({bs_start, bs_stop, busy, done, aborted, err_tmo} !== 6'b0 || scan_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got start=%b stop=%b busy=%b done=%b abt=%b tmo=%b cnt=%0d, expected all 0",
                  bs_start, bs_stop, busy, done, aborted, err_tmo, scan_cnt);
      end
      checks++;
      if ({t_bs_start, t_bs_stop, t_busy, t_done, t_aborted, t_err_tmo} !== 6'b0 || t_scan_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs_t: got nonzero status, expected all 0");
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_directed_scans();
      run_scans(3, 10, 20, "three_scans");
   endtask

   task automatic test_zero_scans();
      run_scans(0, 5, 3, "zero_scans");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 6; r++) begin
         run_scans($urandom_range(1, 4), $urandom_range(0, 12), $urandom_range(1, 10), "random_run");
      end
   endtask

   task automatic test_prefill_wait();
      int n0, x, sb;
      sb = start_log.size();
      dend_ofs = 4;
      fifo_lvl = 10'd8;
      start_run(1, 0, n0);
      advance_to(n0 + 100);
      fifo_lvl = 10'd15;
      advance_to(n0 + 110);
      fifo_lvl = 10'd16;
      x = cyc;
      wait_idle(40, "prefill_wait");
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (start_log.size() - sb != 1 || start_log[sb] != x + 2) begin
         errors++;
         $display("FAIL prefill_wait start: got %0d starts, first at %0d, expected 1 at %0d",
                  start_log.size() - sb, (start_log.size() > sb) ? start_log[sb] : -1, x + 2);
      end
      checks++;
      if (err_tmo !== 1'b0 || int'(scan_cnt) != 1) begin
         errors++;
         $display("FAIL prefill_wait status: got tmo=%b cnt=%0d, expected tmo=0 cnt=1", err_tmo, scan_cnt);
      end
   endtask

   task automatic test_prefill_timeout();
      int n0, nst, ndn, bad, nstop;
      nst = 0; ndn = 0; bad = 0; nstop = 0;
      t_lvl = 10'd8;
      @(posedge clk); #1;
      t_start = 1'b1; n0 = cyc;
      @(posedge clk); #1;
      t_start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (t_bs_start) nst++;
         if (t_done) ndn++;
         if (t_err_tmo !== 1'b0 || t_busy !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tmo_during_prefill: %0d bad cycles, expected 0 (busy=1, tmo=0 for 50 cycles)", bad);
      end
      checks++;
      if (t_err_tmo !== 1'b1 || t_busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_expire: got tmo=%b busy=%b at cycle %0d, expected tmo=1 busy=0", t_err_tmo, t_busy, cyc - n0);
      end
      checks++;
      if (nst != 0 || ndn != 0 || t_done !== 1'b0 || t_bs_start !== 1'b0) begin
         errors++;
         $display("FAIL tmo_no_start_done: got starts=%0d dones=%0d, expected 0 0", nst, ndn);
      end

      // Abort in the very cycle the timeout would fire.
      @(posedge clk); #1;
      t_start = 1'b1; n0 = cyc;
      @(posedge clk); #1;
      t_start = 1'b0;
      checks++;
      if (t_err_tmo !== 1'b0) begin
         errors++;
         $display("FAIL tmo_cleared_by_start: got %b, expected 0", t_err_tmo);
      end
      advance_to(n0 + 50);
      t_abort = 1'b1;
      @(posedge clk); #1;
      t_abort = 1'b0;
      checks++;
      if (t_err_tmo !== 1'b0 || t_aborted !== 1'b1 || t_bs_stop !== 1'b1) begin
         errors++;
         $display("FAIL abort_vs_tmo: got tmo=%b abt=%b stop=%b, expected 0 1 1", t_err_tmo, t_aborted, t_bs_stop);
      end
      for (int i = 0; i < 6; i++) begin
         if (t_bs_stop) nstop++;
         @(posedge clk); #1;
      end
      checks++;
      if (nstop != 4 || t_busy !== 1'b0 || t_err_tmo !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_tmo_end: got stop_cycles=%0d busy=%b tmo=%b, expected 4 0 0", nstop, t_busy, t_err_tmo);
      end
   endtask

   task automatic test_abort_run();
      int n0, a, sb, db, pb, fb;
      sb = start_log.size(); db = done_log.size(); pb = stop_log.size(); fb = fall_log.size();
      dend_ofs = 15;
      fifo_lvl = 10'd64;
      start_run(3, 5, n0);
      wait_starts(sb + 2, 200, "abort_run");
      repeat (4) @(posedge clk);
      #1;
      a = cyc;
      cmd_abort = 1'b1;
      @(posedge clk); #1;
      cmd_abort = 1'b0;
      wait_idle(20, "abort_run");
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (stop_log.size() - pb != 4 || stop_log[pb] != a + 1 || stop_log[stop_log.size() - 1] != a + 4) begin
         errors++;
         $display("FAIL abort_run stop: got %0d cycles from %0d, expected 4 from %0d",
                  stop_log.size() - pb, (stop_log.size() > pb) ? stop_log[pb] : -1, a + 1);
      end
      checks++;
      if (aborted !== 1'b1 || int'(scan_cnt) != 1) begin
         errors++;
         $display("FAIL abort_run status: got abt=%b cnt=%0d, expected 1 1", aborted, scan_cnt);
      end
      checks++;
      if (done_log.size() != db || start_log.size() - sb != 2) begin
         errors++;
         $display("FAIL abort_run events: got dones=%0d starts=%0d, expected 0 2", done_log.size() - db, start_log.size() - sb);
      end
      checks++;
      if (fall_log.size() <= fb || fall_log[fb] != a + 5) begin
         errors++;
         $display("FAIL abort_run busy_fall: got %0d, expected %0d", (fall_log.size() > fb) ? fall_log[fb] : -1, a + 5);
      end
      start_run(0, 0, n0);
      checks++;
      if (aborted !== 1'b0) begin
         errors++;
         $display("FAIL abort_cleared_by_start: got %b, expected 0", aborted);
      end
      wait_idle(10, "abort_restart");
   endtask

   task automatic test_abort_final_dend();
      int n0, s2, sb, db, pb;
      sb = start_log.size(); db = done_log.size(); pb = stop_log.size();
      dend_ofs = 8;
      fifo_lvl = 10'd64;
      start_run(2, 0, n0);
      wait_starts(sb + 2, 100, "abort_final");
      s2 = (start_log.size() > sb + 1) ? start_log[sb + 1] : cyc;
      advance_to(s2 + 8);
      cmd_abort = 1'b1;
      @(posedge clk); #1;
      cmd_abort = 1'b0;
      wait_idle(20, "abort_final");
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (aborted !== 1'b1 || int'(scan_cnt) != 1 || done_log.size() != db) begin
         errors++;
         $display("FAIL abort_final: got abt=%b cnt=%0d dones=%0d, expected 1 1 0", aborted, scan_cnt, done_log.size() - db);
      end
      checks++;
      if (stop_log.size() - pb != 4) begin
         errors++;
         $display("FAIL abort_final stop: got %0d cycles, expected 4", stop_log.size() - pb);
      end
   endtask

   task automatic test_stray_and_reset();
      int n0, sb, pb;
      pb = stop_log.size();
      // A clean run first so ABORTED is low, then abort while idle.
      run_scans(1, 0, 3, "pre_idle_abort");
      cmd_abort = 1'b1;
      @(posedge clk); #1;
      cmd_abort = 1'b0;
      @(posedge clk); #1;
      pb = stop_log.size();
      checks++;
      if (aborted !== 1'b0 || busy !== 1'b0 || bs_stop !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort: got abt=%b busy=%b stop=%b, expected 0 0 0", aborted, busy, bs_stop);
      end

      sb = start_log.size();
      dend_ofs = 5;
      fifo_lvl = 10'd64;
      start_run(2, 30, n0);
      dend_man = 1'b1;
      @(posedge clk); #1;
      dend_man = 1'b0;
      advance_to(n0 + 4);
      num_scans = 16'd5;
      cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      advance_to(n0 + 12);
      dend_man = 1'b1;
      @(posedge clk); #1;
      dend_man = 1'b0;
      advance_to(n0 + 15);
      checks++;
      if (int'(scan_cnt) != 1 || busy !== 1'b1 || start_log.size() - sb != 1) begin
         errors++;
         $display("FAIL stray_inputs: got cnt=%0d busy=%b starts=%0d, expected 1 1 1", scan_cnt, busy, start_log.size() - sb);
      end

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bs_start, bs_stop, busy, done, aborted, err_tmo} !== 6'b0 || scan_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: got start=%b stop=%b busy=%b done=%b abt=%b tmo=%b cnt=%0d, expected all 0",
                  bs_start, bs_stop, busy, done, aborted, err_tmo, scan_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (stop_log.size() != pb || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_stop: got stop_cycles=%0d busy=%b, expected 0 0", stop_log.size() - pb, busy);
      end
      run_scans(2, 3, 6, "post_reset");
   endtask

   initial begin
      test_reset();
      test_directed_scans();
      test_zero_scans();
      test_back_to_back();
      test_prefill_wait();
      test_prefill_timeout();
      test_abort_run();
      test_abort_final_dend();
      test_stray_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
